// File: rtl/spi3w_pkg.sv
// spi3w_pkg: shared types, frame timing helper and elaboration checks for the
// 3-wire SPI master.
`ifndef SPI3W_PKG_SV
`define SPI3W_PKG_SV

// Elaboration-time parameter guard: a failing condition stops elaboration.
`define SPI3W_PARAM_CHECK(name, cond, msg) \
    if (!(cond)) begin : name \
        $fatal(1, msg); \
    end

package spi3w_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_LO,
        SHIFT_HI,
        HOLD,
        DONE
    } spi3w_state_e;

    // Cycles SCEN stays low for one frame: SETUP + 2 half-periods per bit + HOLD.
    function automatic int unsigned spi3w_frame_cycles(input int unsigned frame_w,
                                                       input int unsigned clk_div);
        return clk_div * (2 * frame_w + 2);
    endfunction

endpackage

`endif

// File: rtl/spi3w_phase_tick.sv
// spi3w_phase_tick: CLK_DIV-cycle down-counter that flags the last cycle of
// each timed phase. Reloaded whenever the FSM enters a new state.
module spi3w_phase_tick
    import spi3w_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic last_o
);
    localparam int            CW     = $clog2(CLK_DIV);
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign last_o = (cnt_q == '0);

    // Count down; reload on state entry or after the final cycle of a phase.
    always_comb begin
        cnt_d = cnt_q - CW'(1);
        if (clr_i || last_o) begin
            cnt_d = RELOAD;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi3w_master.sv
// spi3w_master: parametrised 3-wire SPI master (SPC idle high, launch on the
// falling edge, slave samples on the rising edge). Supports write frames and
// read frames that turn the shared SDAT line around after CMD_W bits.
module spi3w_master
    import spi3w_pkg::*;
#(
    parameter int FRAME_W = 16,
    parameter int CMD_W   = 8,
    parameter int CLK_DIV = 4
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     GO,
    input  logic                     RD,
    input  logic [FRAME_W-1:0]       regdata,
    output logic                     SPC,
    output logic                     SCEN,
    inout  wire                      SDAT,
    output logic                     ORDY,
    output logic [FRAME_W-CMD_W-1:0] rdata,
    output logic                     rvalid
);
    `SPI3W_PARAM_CHECK(g_chk_cmd_w, CMD_W < FRAME_W, "spi3w_master: CMD_W must be less than FRAME_W")
    `SPI3W_PARAM_CHECK(g_chk_div, CLK_DIV >= 2, "spi3w_master: CLK_DIV must be at least 2")

    localparam int            RW       = FRAME_W - CMD_W;
    localparam int            BW       = $clog2(FRAME_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_W - 1);
    localparam logic [BW-1:0] CMD_BIT  = BW'(CMD_W);

    spi3w_state_e       state_q, state_d;
    logic [FRAME_W-1:0] tx_q, tx_d;
    logic               rd_q, rd_d;
    logic [BW-1:0]      bit_q, bit_d;
    logic [RW-1:0]      rx_q, rx_d;
    logic [RW-1:0]      rdata_q, rdata_d;

    logic phase_last;
    logic sdat_oe;

    // Phase timer restarts on every state change so each phase is CLK_DIV long.
    spi3w_phase_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk_i  (CLK),
        .rst_i  (reset),
        .clr_i  (state_d != state_q),
        .last_o (phase_last)
    );

    // Next-state and datapath: frame sequencing, shifting and read capture.
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rd_d    = rd_q;
        bit_d   = bit_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE, DONE: begin
                // DONE accepts GO too, giving back-to-back frames.
                if (GO) begin
                    state_d = SETUP;
                    tx_d    = regdata;
                    rd_d    = RD;
                    bit_d   = '0;
                    rx_d    = '0;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                if (phase_last) state_d = SHIFT_LO;
            end
            SHIFT_LO: begin
                if (phase_last) state_d = SHIFT_HI;
            end
            SHIFT_HI: begin
                if (phase_last) begin
                    // Slave data bits are captured at the end of the high phase.
                    if (rd_q && (bit_q >= CMD_BIT)) begin
                        rx_d    = rx_q << 1;
                        rx_d[0] = SDAT;
                    end
                    if (bit_q == LAST_BIT) begin
                        // Counter parks on the last bit so it never wraps.
                        state_d = HOLD;
                    end else begin
                        // Next SHIFT_LO presents the following bit on SDAT.
                        state_d = SHIFT_LO;
                        bit_d   = bit_q + BW'(1);
                        tx_d    = tx_q << 1;
                    end
                end
            end
            HOLD: begin
                if (phase_last) begin
                    state_d = DONE;
                    if (rd_q) rdata_d = rx_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= IDLE;
            tx_q    <= '0;
            rd_q    <= 1'b0;
            bit_q   <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rd_q    <= rd_d;
            bit_q   <= bit_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
        end
    end

    // Bus outputs are decoded from registered state, so they are glitch-free.
    assign SPC    = (state_q != SHIFT_LO);
    assign SCEN   = (state_q == IDLE) || (state_q == DONE);
    assign ORDY   = (state_q == IDLE) || (state_q == DONE);
    assign rvalid = (state_q == DONE) && rd_q;
    assign rdata  = rdata_q;

    // Reads release the line from the low phase of bit CMD_W onwards.
    assign sdat_oe = !SCEN && (!rd_q || (bit_q < CMD_BIT));
    assign SDAT    = sdat_oe ? tx_q[FRAME_W-1] : 1'bz;

endmodule

// File: tb/tb_spi3w_master.sv
// tb_spi3w_master: scoreboard bench for spi3w_master. Stimulus pushes expected
// frames / read words; independent monitors watch the wire and pop/compare.
module tb_spi3w_master;
    localparam int FW   = 16;
    localparam int CW   = 8;
    localparam int DIV  = 4;
    localparam int RW   = FW - CW;
    localparam int LAT  = 1 + DIV * (2 * FW + 2);
    localparam int FW2  = 24;
    localparam int CW2  = 16;
    localparam int DIV2 = 2;
    localparam int RW2  = FW2 - CW2;
    localparam int LAT2 = 1 + DIV2 * (2 * FW2 + 2);

    typedef struct {
        bit            rd;
        bit            abort;
        logic [FW-1:0] bits;
        int            t0;
        int            gap;
    } frame_t;

    typedef struct {
        bit            rd;
        logic [RW-1:0] data;
    } slv_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, go, rd;
    logic [FW-1:0] regdata;
    logic          spc, scen, ordy, rvalid;
    logic [RW-1:0] rdata;
    wire           sdat;
    logic          slv_oe, slv_bit;

    logic           go2, rd2;
    logic [FW2-1:0] regdata2;
    logic           spc2, scen2, ordy2, rvalid2;
    logic [RW2-1:0] rdata2;
    wire            sdat2;
    logic           slv2_oe, slv2_bit;

    pullup (sdat);
    pullup (sdat2);
    assign sdat  = slv_oe  ? slv_bit  : 1'bz;
    assign sdat2 = slv2_oe ? slv2_bit : 1'bz;

    spi3w_master #(.FRAME_W(FW), .CMD_W(CW), .CLK_DIV(DIV)) dut (
        .CLK(clk), .reset(reset), .GO(go), .RD(rd), .regdata(regdata),
        .SPC(spc), .SCEN(scen), .SDAT(sdat), .ORDY(ordy),
        .rdata(rdata), .rvalid(rvalid)
    );

    spi3w_master #(.FRAME_W(FW2), .CMD_W(CW2), .CLK_DIV(DIV2)) dut2 (
        .CLK(clk), .reset(reset), .GO(go2), .RD(rd2), .regdata(regdata2),
        .SPC(spc2), .SCEN(scen2), .SDAT(sdat2), .ORDY(ordy2),
        .rdata(rdata2), .rvalid(rvalid2)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    frame_t        exp_q[$];
    logic [RW-1:0] rexp_q[$];
    slv_t          slv_q[$];
    logic [RW2-1:0] slv2_data = 8'h5A;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Wait (bounded) until the master reports ready.
    task automatic wait_ready();
        int n = 0;
        int lim = int'(spi3w_pkg::spi3w_frame_cycles(FW, DIV)) + 20;
        while (!ordy && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (!ordy) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: ORDY still low after %0d cycles", n);
        end
    endtask

    // Reference model: what the wire and rdata must show for one frame.
    task automatic push_frame(input bit r, input logic [FW-1:0] d,
                              input logic [RW-1:0] s, input bit ab, input int gap);
        frame_t f;
        slv_t   sv;
        f.rd    = r;
        f.abort = ab;
        f.bits  = r ? {d[FW-1 -: CW], s} : d;
        f.t0    = cyc;
        f.gap   = gap;
        exp_q.push_back(f);
        sv.rd   = r;
        sv.data = s;
        slv_q.push_back(sv);
        if (r && !ab) rexp_q.push_back(s);
    endtask

    // Issue one frame; inputs are scrambled after acceptance to prove latching.
    task automatic start(input bit r, input logic [FW-1:0] d,
                         input logic [RW-1:0] s, input bit ab);
        wait_ready();
        go = 1'b1;
        rd = r;
        regdata = d;
        push_frame(r, d, s, ab, -1);
        @(negedge clk);
        go = 1'b0;
        rd = 1'($urandom);
        regdata = FW'($urandom);
    endtask

    // Wire monitor: collects bits on SPC rising edges, checks against scoreboard.
    initial begin
        logic          spc_p = 1'b1, scen_p = 1'b1, rv_p = 1'b0;
        bit            in_frame = 0;
        int            lo_len = 0, hi_len = 0, nbits = 0;
        logic [FW-1:0] cap = '0;
        frame_t        cur;
        forever begin
            @(negedge clk);
            if (scen_p && !scen) begin
                in_frame = 1;
                nbits = 0;
                cap = '0;
                lo_len = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: frame started with nothing expected at cycle %0d", cyc);
                end else if (exp_q[0].gap >= 0) begin
                    chk("scen_gap", 64'(hi_len), 64'(exp_q[0].gap));
                end
            end
            if (in_frame && !scen) begin
                lo_len++;
                if (!spc_p && spc) begin
                    if (nbits < FW) cap[FW-1-nbits] = sdat;
                    nbits++;
                end
            end
            if (in_frame && scen) begin
                in_frame = 0;
                if (exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    if (!cur.abort) begin
                        chk("frame_bits", 64'(cap), 64'(cur.bits));
                        chk("frame_nbits", 64'(nbits), 64'(FW));
                        chk("scen_low_len", 64'(lo_len), 64'(LAT - 1));
                        chk("ordy_latency", 64'(cyc), 64'(cur.t0 + LAT));
                        chk("ordy_at_end", 64'(ordy), 64'(1));
                    end
                end
                hi_len = 0;
            end
            if (scen) hi_len++;
            if (rvalid) begin
                chk("rvalid_one_cycle", 64'(rv_p), 64'(0));
                if (rexp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rvalid: rvalid with rdata %0h at cycle %0d", rdata, cyc);
                end else begin
                    chk("rdata", 64'(rdata), 64'(rexp_q.pop_front()));
                end
            end
            spc_p = spc;
            scen_p = scen;
            rv_p = rvalid;
        end
    end

    // Slave model for the default instance: answers reads after turnaround.
    initial begin
        logic spc_p = 1'b1, scen_p = 1'b1;
        int   fall = 0, pend = -1;
        bit   act = 0;
        slv_t cur;
        slv_oe = 1'b0;
        slv_bit = 1'b0;
        forever begin
            @(negedge clk);
            if (scen_p && !scen) begin
                fall = 0;
                pend = -1;
                act = 0;
                if (slv_q.size() > 0) begin
                    cur = slv_q.pop_front();
                    act = 1;
                end
            end
            if (scen) begin
                slv_oe = 1'b0;
                pend = -1;
            end
            if (pend >= 0) begin
                slv_oe = 1'b1;
                slv_bit = cur.data[RW-1-pend];
                pend = -1;
            end
            if (!scen && spc_p && !spc) begin
                if (act && cur.rd && fall >= CW) begin
                    if (fall == CW) chk("sdat_released", 64'(sdat), 64'(1));
                    pend = fall - CW;
                end
                fall++;
            end
            spc_p = spc;
            scen_p = scen;
        end
    end

    // Slave model for the wide instance: drives data bits from bit CMD_W on.
    initial begin
        logic spc_p = 1'b1;
        int   fall = 0;
        slv2_oe = 1'b0;
        slv2_bit = 1'b0;
        forever begin
            @(negedge clk);
            if (scen2) begin
                slv2_oe = 1'b0;
                fall = 0;
            end else if (spc_p && !spc2) begin
                if (fall >= CW2) begin
                    slv2_oe = 1'b1;
                    slv2_bit = slv2_data[RW2-1-(fall-CW2)];
                end
                fall++;
            end
            spc_p = spc2;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d errors so far", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int t2, n;
        reset = 1'b1; go = 1'b0; rd = 1'b0; regdata = '0;
        go2 = 1'b0; rd2 = 1'b0; regdata2 = '0;
        repeat (3) @(negedge clk);
        chk("rst_spc", 64'(spc), 64'(1));
        chk("rst_scen", 64'(scen), 64'(1));
        chk("rst_ordy", 64'(ordy), 64'(1));
        chk("rst_rvalid", 64'(rvalid), 64'(0));
        chk("rst_rdata", 64'(rdata), 64'(0));
        chk("rst_sdat_z", 64'(sdat), 64'(1));
        reset = 1'b0;
        @(negedge clk);

        // Directed write and read.
        start(1'b0, 16'hA55A, 8'h00, 1'b0);
        wait_ready(); repeat (4) @(negedge clk);
        start(1'b1, 16'h8300, 8'hC3, 1'b0);
        wait_ready(); repeat (4) @(negedge clk);

        // Back-to-back: GO held high through DONE, write then read.
        wait_ready();
        go = 1'b1; rd = 1'b0; regdata = 16'h5AF0;
        push_frame(1'b0, 16'h5AF0, 8'h00, 1'b0, -1);
        @(negedge clk);
        rd = 1'b1; regdata = 16'h9E00;
        repeat (3) @(negedge clk);
        wait_ready();
        push_frame(1'b1, 16'h9E00, 8'h3B, 1'b0, 1);
        @(negedge clk);
        go = 1'b0;
        wait_ready(); repeat (4) @(negedge clk);

        // GO while busy is ignored.
        start(1'b0, 16'h3C96, 8'h00, 1'b0);
        repeat (19) @(negedge clk);
        go = 1'b1; rd = 1'b1; regdata = 16'hFFFF;
        @(negedge clk);
        go = 1'b0;
        wait_ready(); repeat (4) @(negedge clk);

        // Reset mid-frame aborts a read.
        start(1'b1, 16'h8100, 8'h77, 1'b1);
        repeat (49) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_spc", 64'(spc), 64'(1));
        chk("abort_scen", 64'(scen), 64'(1));
        chk("abort_sdat_z", 64'(sdat), 64'(1));
        chk("abort_ordy", 64'(ordy), 64'(1));
        chk("abort_rvalid", 64'(rvalid), 64'(0));
        chk("abort_rdata", 64'(rdata), 64'(0));
        reset = 1'b0;
        @(negedge clk);
        start(1'b0, 16'h1234, 8'h00, 1'b0);

        // Randomized frames with random idle gaps (0 allows back-to-back).
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            start(1'($urandom), FW'($urandom), RW'($urandom), 1'b0);
        end
        wait_ready(); repeat (6) @(negedge clk);
        chk("frames_pending", 64'(exp_q.size()), 64'(0));
        chk("reads_pending", 64'(rexp_q.size()), 64'(0));

        // Wide-frame instance: 24-bit frame, 16 command bits, CLK_DIV=2.
        go2 = 1'b1; rd2 = 1'b1; regdata2 = 24'h8A1F00;
        t2 = cyc;
        @(negedge clk);
        go2 = 1'b0; regdata2 = '0;
        n = 0;
        while (!rvalid2 && n < LAT2 + 20) begin
            @(negedge clk);
            n++;
        end
        chk("sweep_latency", 64'(cyc), 64'(t2 + LAT2));
        chk("sweep_rdata", 64'(rdata2), 64'(8'h5A));
        chk("sweep_ordy", 64'(ordy2), 64'(1));
        @(negedge clk);
        chk("sweep_rvalid_one", 64'(rvalid2), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
